// File: rtl/led_scan_controller.sv
// LED array column scan front end.
// Walks the column index through 0..N-1 with a blanking gap and a drive
// dwell per column, and double-buffers the displayed grid so that a new
// generation from the stepper only becomes visible at a frame boundary.
module led_scan_controller #(
  parameter int N            = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*N-1:0]       cells_in,
  input  logic                 cells_valid,
  output logic                 cells_ready,
  output logic                 ena,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_start
);

  localparam int XW   = $clog2(N) + 1;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Elaboration-time parameter sanity checks; no hardware is produced.
  initial begin
    if (N < 1 || N > 8)    $error("led_scan_controller: N=%0d outside 1..8", N);
    if (DWELL_CYCLES < 1)  $error("led_scan_controller: DWELL_CYCLES must be >= 1");
    if (BLANK_CYCLES < 1)  $error("led_scan_controller: BLANK_CYCLES must be >= 1");
  end

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  x_q, x_d;
  logic [N*N-1:0] cells_q, cells_d;
  logic [N*N-1:0] pend_q, pend_d;
  logic           pend_full_q, pend_full_d;
  logic           fs_q, fs_d;
  logic           wrap;
  logic           xfer;

  // Scan FSM: phase counter, column advance and frame wrap detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    x_d     = x_q;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (x_q == XW'(N - 1)) begin
            x_d  = '0;
            wrap = 1'b1;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Grid buffering: accept into pending when empty, swap into display on wrap.
  // Swap and transfer are mutually exclusive because ready is low while full.
  always_comb begin
    xfer        = cells_valid && !pend_full_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cells_d     = cells_q;
    fs_d        = wrap;
    if (wrap && pend_full_q) begin
      cells_d     = pend_q;
      pend_full_d = 1'b0;
    end else if (xfer) begin
      pend_d      = cells_in;
      pend_full_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      x_q         <= '0;
      cells_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      cells_q     <= cells_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      fs_q        <= fs_d;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    ena         = (state_q == ST_DRIVE);
    x           = x_q;
    cells       = cells_q;
    cells_ready = !pend_full_q;
    frame_start = fs_q;
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with N=8, dwell 4, blank 2
// (column period 6, frame period 48). Cycle k is the clock period after
// the k-th rising edge following reset release.
module tb_led_scan_controller;

  localparam int N  = 8;
  localparam int DW = 4;
  localparam int BL = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*N-1:0] cells_in;
  logic           cells_valid;
  logic           cells_ready;
  logic           ena;
  logic [3:0]     x;
  logic [N*N-1:0] cells;
  logic           frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int cur      = 0;

  always #5 clk = ~clk;

  led_scan_controller #(
    .N            (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cells_in    (cells_in),
    .cells_valid (cells_valid),
    .cells_ready (cells_ready),
    .ena         (ena),
    .x           (x),
    .cells       (cells),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold reset over two edges, release mid-cycle; that half cycle is cycle 0.
  task automatic do_reset();
    rst_n       = 1'b0;
    cells_valid = 1'b0;
    cells_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cur = 0;
  endtask

  task automatic adv_to(input int k);
    while (cur < k) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  initial begin
    logic [3:0] prev_x;
    logic       prev_ena;

    rst_n       = 1'b1;
    cells_valid = 1'b0;
    cells_in    = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ena",   ena,         1'b0);
    check("rst_x",     x,           4'd0);
    check("rst_cells", cells,       64'h0);
    check("rst_fs",    frame_start, 1'b0);
    check("rst_ready", cells_ready, 1'b1);

    // Idle scan over two frames.
    do_reset();
    for (int k = 0; k <= 100; k++) begin
      adv_to(k);
      check("idle_ena",   ena,         ((k % 6) >= 2) ? 1'b1 : 1'b0);
      check("idle_x",     x,           4'((k / 6) % 8));
      check("idle_fs",    frame_start, (k == 48 || k == 96) ? 1'b1 : 1'b0);
      check("idle_cells", cells,       64'h0);
    end

    // Single push displayed at the first wrap.
    do_reset();
    adv_to(5);
    check("p1_ready5", cells_ready, 1'b1);
    cells_in    = 64'h00000000000000FF;
    cells_valid = 1'b1;
    adv_to(6);
    check("p1_ready6", cells_ready, 1'b0);
    cells_valid = 1'b0;
    cells_in    = '0;
    adv_to(47);
    check("p1_cells47", cells,       64'h0);
    check("p1_ready47", cells_ready, 1'b0);
    adv_to(48);
    check("p1_cells48", cells,       64'hFF);
    check("p1_fs48",    frame_start, 1'b1);
    check("p1_ready48", cells_ready, 1'b1);

    // A accepted, B stalled until frame 1 starts.
    do_reset();
    adv_to(3);
    cells_in    = 64'h1;
    cells_valid = 1'b1;
    adv_to(4);
    check("ab_ready4", cells_ready, 1'b0);
    cells_in = 64'h2;
    adv_to(47);
    check("ab_ready47", cells_ready, 1'b0);
    check("ab_cells47", cells,       64'h0);
    adv_to(48);
    check("ab_ready48", cells_ready, 1'b1);
    check("ab_cells48", cells,       64'h1);
    adv_to(49);
    check("ab_ready49", cells_ready, 1'b0);
    cells_valid = 1'b0;
    cells_in    = '0;
    adv_to(95);
    check("ab_cells95", cells, 64'h1);
    adv_to(96);
    check("ab_cells96", cells,       64'h2);
    check("ab_ready96", cells_ready, 1'b1);

    // Transfer on the wrap edge lands in pending, shown one frame later.
    do_reset();
    adv_to(47);
    cells_in    = 64'h55;
    cells_valid = 1'b1;
    adv_to(48);
    check("wr_ready48", cells_ready, 1'b0);
    check("wr_cells48", cells,       64'h0);
    check("wr_fs48",    frame_start, 1'b1);
    cells_valid = 1'b0;
    cells_in    = '0;
    adv_to(95);
    check("wr_cells95", cells, 64'h0);
    adv_to(96);
    check("wr_cells96", cells, 64'h55);

    // Asynchronous reset in column 5 DRIVE with a pending grid.
    do_reset();
    adv_to(3);
    cells_in    = 64'hA5A5;
    cells_valid = 1'b1;
    adv_to(4);
    cells_valid = 1'b0;
    adv_to(48);
    check("ar_cells48", cells, 64'hA5A5);
    adv_to(50);
    cells_in    = 64'h3C;
    cells_valid = 1'b1;
    adv_to(51);
    check("ar_ready51", cells_ready, 1'b0);
    cells_valid = 1'b0;
    adv_to(81);
    check("ar_ena81", ena, 1'b1);
    check("ar_x81",   x,   4'd5);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ena",   ena,         1'b0);
    check("ar_x",     x,           4'd0);
    check("ar_cells", cells,       64'h0);
    check("ar_ready", cells_ready, 1'b1);
    do_reset();
    adv_to(48);
    check("ar_cells_f1", cells,       64'h0);
    check("ar_fs_f1",    frame_start, 1'b1);
    check("ar_ready_f1", cells_ready, 1'b1);
    adv_to(96);
    check("ar_cells_f2", cells, 64'h0);

    // x range and stability while driving, three frames.
    do_reset();
    prev_x   = x;
    prev_ena = ena;
    for (int k = 0; k < 144; k++) begin
      adv_to(k);
      check("x_range", (x <= 4'd7) ? 1'b1 : 1'b0, 1'b1);
      if (k > 0 && ena && prev_ena) check("x_stable_ena", x, prev_x);
      prev_x   = x;
      prev_ena = ena;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_scan_controller.md
Name: led_scan_controller

Overview:
- Sequential front end for the LED array column driver.
- Time-multiplexes the column select index `x` and the enable `ena` across the N columns with a fixed dwell per column and a blanking gap between columns.
- Holds the displayed Conway grid in a display register and accepts each new generation from the game-of-life stepper into a pending register through a valid/ready handshake.
- Swaps the pending grid into the display register only at frame boundaries, so a frame never shows two generations.

Parameters:
- N, 8: grid size. Legal range is 1..8; `$error` in an initial block if outside.
- DWELL_CYCLES, 1000: clock cycles per column with `ena` high. Must be >=1; `$error` otherwise.
- BLANK_CYCLES, 2: clock cycles per column with `ena` low before drive (anti-ghosting). Must be >=1; `$error` otherwise.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- cells_in, input, N*N: next generation from stepper. Row r occupies bits [r*N+N-1 : r*N].
- cells_valid, input, 1: cells_in is valid this cycle.
- cells_ready, output, 1: pending register empty. A transfer occurs when cells_valid && cells_ready.
- ena, output, 1: column driver enable.
- x, output, $clog2(N)+1: current column index, 0..N-1.
- cells, output, N*N: displayed grid to the column driver.
- frame_start, output, 1: one-cycle pulse at the start of column 0.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock required):
  - ena=0, x=0, cells=0, frame_start=0, cells_ready=1.
  - Pending register empty; state BLANK; phase counter 0.
- State machine, two states:
  - BLANK: ena=0. Stay BLANK_CYCLES cycles, then go to DRIVE with counter cleared.
  - DRIVE: ena=1. Stay DWELL_CYCLES cycles. On the last cycle, go to BLANK with counter cleared and x advancing. x=N-1 wraps to 0; otherwise x increments by 1.
- Counter: one phase counter, wide enough for max(DWELL_CYCLES, BLANK_CYCLES). It counts from 0 to limit-1, and the transition occurs on the edge after count limit-1.
- x changes only on the DRIVE->BLANK edge, never while ena=1.
- Timing: column period is BLANK_CYCLES+DWELL_CYCLES; frame period is N*(BLANK_CYCLES+DWELL_CYCLES). After reset release, the first edge starts counting column 0 BLANK.
- frame_start:
  - High for exactly one cycle: the first BLANK cycle of column 0, i.e. the cycle after the wrap edge.
  - Not asserted for the first frame after reset.
- Handshake:
  - cells_ready = !pending_full, registered state with no combinational path from cells_valid.
  - On transfer: pending <= cells_in; pending_full <= 1.
  - cells_valid while cells_ready=0 is ignored; the stepper must hold its data.
- Swap, on the wrap edge (DRIVE of x=N-1 -> BLANK of x=0):
  - If pending_full: cells <= pending, pending_full <= 0, so cells_ready rises in the first cycle of the new frame.
  - If the pending register is empty, cells is unchanged.
- Simultaneous events:
  - A transfer on the wrap edge with the pending register previously empty lands in pending. It is not displayed until the next wrap; there is no bypass.
  - A transfer is impossible on a wrap edge where a swap occurs, because cells_ready=0 then.
- cells changes only on wrap edges and reset.
- Reset mid-frame: all state returns to the reset values above and any pending grid is discarded. Scanning restarts at column 0 BLANK.
- N=1: x stays 0; every DRIVE end is a wrap.

Test Plan:
Common setup: N=8, DWELL_CYCLES=4, BLANK_CYCLES=2 (column period 6, frame 48).
- Reset then idle 100 cycles:
  - ena pattern is 0,0,1,1,1,1 per column.
  - x sequence is 0..7, 0.
  - frame_start pulses at cycles 48 and 96 after release.
  - cells stays 0.
- Push cells_in=64'h00000000000000FF with valid at cycle 5:
  - cells_ready drops at cycle 6.
  - cells stays 0 until the wrap edge, then becomes 64'hFF coincident with the frame_start cycle.
  - cells_ready returns to 1 in that cycle.
- Push A=64'h1 at cycle 3, then hold B=64'h2 valid continuously:
  - B is stalled (cells_ready=0) until frame 1 starts.
  - B is accepted in the first cycle of frame 1.
  - cells=A in frame 1 and cells=B in frame 2.
- Assert cells_valid exactly on the wrap edge cycle with pending empty:
  - The grid is accepted but cells changes only at the following wrap, 48 cycles later.
- Assert rst_n low asynchronously mid-DRIVE of column 5 with a pending grid:
  - ena=0, x=0, cells=0 and cells_ready=1 appear immediately, before any clock edge.
  - After release, the pending grid never appears.
- Check x on every cycle where ena=1 across 3 frames:
  - x is never observed changing while ena=1.
  - x never exceeds 7.
